// File: rtl/ext_pkg.sv
// Shared definitions for the decode-stage immediate generator: extension-op
// bit positions, skid-buffer states and the buffered payload layout.
package ext_pkg;

   localparam int EXTOP_W_DEF = 7;
   localparam int XLEN_MAX    = 64;

   localparam int EXTOP_JTYPE   = 0;
   localparam int EXTOP_UTYPE   = 1;
   localparam int EXTOP_BTYPE   = 2;
   localparam int EXTOP_STYPE   = 3;
   localparam int EXTOP_ITYPE   = 4;
   localparam int EXTOP_SHAMT   = 5;
   localparam int EXTOP_CSRTYPE = 6;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } ext_state_t;

   // Sized for the widest legal XLEN; narrower configurations use the low bits.
   typedef struct packed {
      logic [XLEN_MAX-1:0] imm;
      logic [XLEN_MAX-1:0] target;
      logic                err;
   } ext_payload_t;

   function automatic logic isOneHot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// Pure combinational immediate formation: picks the field layout selected by
// the one-hot op, extends it to XLEN and adds the PC.
module imm_ext_comb
   import ext_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int EXTOP_W = EXTOP_W_DEF
) (
   input  logic [31:0]        i_instr,
   input  logic [XLEN-1:0]    i_pc,
   input  logic [EXTOP_W-1:0] i_extop,
   output logic [XLEN-1:0]    o_imm,
   output logic [XLEN-1:0]    o_target,
   output logic               o_err
);

   logic [XLEN-1:0] w_immShamt;
   logic [XLEN-1:0] w_immI;
   logic [XLEN-1:0] w_immS;
   logic [XLEN-1:0] w_immB;
   logic [XLEN-1:0] w_immJ;
   logic [XLEN-1:0] w_immU;
   logic [XLEN-1:0] w_immCsr;
   logic [XLEN-1:0] w_immSel;
   logic            w_oneHot;
   logic            w_unusedOpcode;

   // The opcode field never contributes to an immediate.
   assign w_unusedOpcode = ^i_instr[6:0];

   generate
      if (XLEN == 64) begin : g_shamt64
         assign w_immShamt = XLEN'(i_instr[25:20]);
      end else begin : g_shamt32
         assign w_immShamt = XLEN'(i_instr[24:20]);
      end
   endgenerate

   assign w_immI   = XLEN'($signed(i_instr[31:20]));
   assign w_immS   = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
   assign w_immB   = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                    i_instr[11:8], 1'b0}));
   assign w_immJ   = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                    i_instr[30:21], 1'b0}));
   assign w_immU   = XLEN'($signed({i_instr[31:12], 12'b0}));
   assign w_immCsr = XLEN'(i_instr[19:15]);

   assign w_oneHot = isOneHot(32'(i_extop));

   always_comb begin
      w_immSel = '0;
      if (i_extop[EXTOP_SHAMT]) begin
         w_immSel = w_immShamt;
      end else if (i_extop[EXTOP_ITYPE]) begin
         w_immSel = w_immI;
      end else if (i_extop[EXTOP_STYPE]) begin
         w_immSel = w_immS;
      end else if (i_extop[EXTOP_BTYPE]) begin
         w_immSel = w_immB;
      end else if (i_extop[EXTOP_UTYPE]) begin
         w_immSel = w_immU;
      end else if (i_extop[EXTOP_JTYPE]) begin
         w_immSel = w_immJ;
      end else if (i_extop[EXTOP_CSRTYPE]) begin
         w_immSel = w_immCsr;
      end
   end

   // A malformed op must not leak a partial immediate or a PC into the payload.
   always_comb begin
      o_imm    = '0;
      o_target = '0;
      o_err    = 1'b1;
      if (w_oneHot) begin
         o_imm    = w_immSel;
         o_target = i_pc + w_immSel;
         o_err    = 1'b0;
      end
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate generator behind a 2-entry skid buffer; in_ready
// comes straight from a flop so no combinational path crosses the block.
module imm_ext_pipe
   import ext_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int EXTOP_W = EXTOP_W_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [EXTOP_W-1:0] in_extop,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_imm,
   output logic [XLEN-1:0]    out_target,
   output logic               out_err
);

   generate
      if (!(XLEN == 32 || XLEN == 64)) begin : g_badXlen
         $error("imm_ext_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   ext_state_t      r_state;
   ext_state_t      w_stateNext;
   logic            r_inReady;
   ext_payload_t    r_head;
   ext_payload_t    r_tail;
   ext_payload_t    w_new;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_target;
   logic            w_err;
   logic            w_accept;
   logic            w_pop;
   logic            w_unusedHi;

   imm_ext_comb #(
      .XLEN    (XLEN),
      .EXTOP_W (EXTOP_W)
   ) u_comb (
      .i_instr  (in_instr),
      .i_pc     (in_pc),
      .i_extop  (in_extop),
      .o_imm    (w_imm),
      .o_target (w_target),
      .o_err    (w_err)
   );

   always_comb begin
      w_new        = '0;
      w_new.imm    = XLEN_MAX'(w_imm);
      w_new.target = XLEN_MAX'(w_target);
      w_new.err    = w_err;
   end

   // A flush cycle drops any presented entry; a pop in that cycle still happens.
   assign w_accept = in_valid & r_inReady & ~flush;
   assign w_pop    = out_valid & out_ready;

   always_comb begin
      w_stateNext = r_state;
      if (flush) begin
         w_stateNext = EMPTY;
      end else begin
         case (r_state)
            EMPTY: if (w_accept) w_stateNext = ONE;
            ONE: begin
               if (w_accept && !w_pop) begin
                  w_stateNext = TWO;
               end else if (!w_accept && w_pop) begin
                  w_stateNext = EMPTY;
               end
            end
            TWO: if (w_pop) w_stateNext = ONE;
            default: w_stateNext = EMPTY;
         endcase
      end
   end

   // r_head is always the oldest entry, so the outputs read it directly.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= EMPTY;
         r_inReady <= 1'b1;
         r_head    <= '0;
         r_tail    <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_inReady <= (w_stateNext != TWO);
         if (!flush) begin
            case (r_state)
               EMPTY: if (w_accept) r_head <= w_new;
               ONE: begin
                  if (w_accept && w_pop) begin
                     r_head <= w_new;
                  end else if (w_accept) begin
                     r_tail <= w_new;
                  end
               end
               TWO: if (w_pop) r_head <= r_tail;
               default: ;
            endcase
         end
      end
   end

   assign in_ready   = r_inReady;
   assign out_valid  = (r_state != EMPTY);
   assign out_imm    = r_head.imm[XLEN-1:0];
   assign out_target = r_head.target[XLEN-1:0];
   assign out_err    = r_head.err;

   // Upper payload bits are zero for XLEN=32 and never reach a port.
   assign w_unusedHi = ^{r_head.imm, r_head.target};

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench: one XLEN=32 and one XLEN=64 instance share a handshake
// and are compared against a queue-based model of the immediate rules.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc32;
   logic [63:0] in_pc64;
   logic [6:0]  in_extop;

   logic        rdy32, vld32, err32;
   logic        rdy64, vld64, err64;
   logic [31:0] imm32, tgt32;
   logic [63:0] imm64, tgt64;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [63:0] imm32;
      logic [63:0] tgt32;
      logic [63:0] imm64;
      logic [63:0] tgt64;
      logic        err;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32), .EXTOP_W(7)) u_dut32 (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (rdy32),
      .in_instr   (in_instr),
      .in_pc      (in_pc32),
      .in_extop   (in_extop),
      .out_valid  (vld32),
      .out_ready  (out_ready),
      .out_imm    (imm32),
      .out_target (tgt32),
      .out_err    (err32)
   );

   imm_ext_pipe #(.XLEN(64), .EXTOP_W(7)) u_dut64 (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (rdy64),
      .in_instr   (in_instr),
      .in_pc      (in_pc64),
      .in_extop   (in_extop),
      .out_valid  (vld64),
      .out_ready  (out_ready),
      .out_imm    (imm64),
      .out_target (tgt64),
      .out_err    (err64)
   );

   // Immediate value as a signed integer, then reduced modulo 2^xlen.
   function automatic logic [63:0] refImm(input logic [31:0] ins, input logic [6:0] op,
                                          input int xlen);
      longint v;
      v = 64'sd0;
      if ($countones(op) != 1) return 64'd0;
      case (op)
         7'h20: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
         7'h10: begin
            v = longint'(ins[31:20]);
            if (v >= 64'sd2048) v = v - 64'sd4096;
         end
         7'h08: begin
            v = longint'({ins[31:25], ins[11:7]});
            if (v >= 64'sd2048) v = v - 64'sd4096;
         end
         7'h04: begin
            v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 64'sd2;
            if (v >= 64'sd4096) v = v - 64'sd8192;
         end
         7'h01: begin
            v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 64'sd2;
            if (v >= 64'sd1048576) v = v - 64'sd2097152;
         end
         7'h02: begin
            v = longint'(ins[31:12]) * 64'sd4096;
            if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
         end
         7'h40: v = longint'(ins[19:15]);
         default: v = 64'sd0;
      endcase
      if (xlen == 32) return {32'd0, v[31:0]};
      return v;
   endfunction

   function automatic exp_t refEntry(input logic [31:0] ins, input logic [6:0] op,
                                     input logic [63:0] pc);
      exp_t e;
      logic [63:0] t32;
      e.err   = ($countones(op) != 1);
      e.imm32 = refImm(ins, op, 32);
      e.imm64 = refImm(ins, op, 64);
      t32     = {32'd0, pc[31:0]} + e.imm32;
      e.tgt32 = e.err ? 64'd0 : {32'd0, t32[31:0]};
      e.tgt64 = e.err ? 64'd0 : pc + e.imm64;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check("valid32", 64'(vld32), 64'(q.size() > 0));
      check("valid64", 64'(vld64), 64'(q.size() > 0));
      check("ready32", 64'(rdy32), 64'(q.size() < 2));
      check("ready64", 64'(rdy64), 64'(q.size() < 2));
      if (q.size() > 0) begin
         check("imm32", {32'd0, imm32}, q[0].imm32);
         check("tgt32", {32'd0, tgt32}, q[0].tgt32);
         check("err32", 64'(err32), 64'(q[0].err));
         check("imm64", imm64, q[0].imm64);
         check("tgt64", tgt64, q[0].tgt64);
         check("err64", 64'(err64), 64'(q[0].err));
      end
   endtask

   // Drive one cycle, advance the model with the pre-edge handshake, then compare.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [6:0] op,
                                input logic [63:0] pc, input logic ordy, input logic fl);
      logic acc;
      logic pop;
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_instr  = ins;
      in_extop  = op;
      in_pc64   = pc;
      in_pc32   = pc[31:0];
      out_ready = ordy;
      flush     = fl;
      acc = v && (q.size() < 2) && !fl;
      pop = (q.size() > 0) && ordy;
      e   = refEntry(ins, op, pc);
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         if (pop) q.delete(0);
         if (acc) q.push_back(e);
      end
      checkOutput();
   endtask

   initial begin
      logic [6:0] ops [8];
      ops = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h00};

      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc32 = '0; in_pc64 = '0; in_extop = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(vld32), 64'd0);
      check("rst_ready", 64'(rdy32), 64'd1);
      check("rst_imm64", imm64, 64'd0);
      check("rst_tgt32", {32'd0, tgt32}, 64'd0);
      check("rst_err64", 64'(err64), 64'd0);
      rstn = 1'b1;

      applyStimulus(1'b1, 32'hFFF00093, 7'h10, 64'h100, 1'b1, 1'b0);
      check("itype_imm", {32'd0, imm32}, 64'hFFFFFFFF);
      check("itype_tgt", {32'd0, tgt32}, 64'hFF);
      check("itype_err", 64'(err32), 64'd0);
      applyStimulus(1'b0, 32'h0, 7'h0, 64'h0, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'hFE000EE3, 7'h04, 64'h200, 1'b1, 1'b0);
      check("btype_imm", {32'd0, imm32}, 64'hFFFFFFFC);
      check("btype_tgt", {32'd0, tgt32}, 64'h1FC);
      applyStimulus(1'b0, 32'h0, 7'h0, 64'h0, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'h800000B7, 7'h02, 64'h0, 1'b1, 1'b0);
      check("utype_imm64", imm64, 64'hFFFFFFFF80000000);
      applyStimulus(1'b1, 32'h03F00000, 7'h20, 64'h0, 1'b1, 1'b0);
      check("shamt_imm64", imm64, 64'h3F);
      check("shamt_imm32", {32'd0, imm32}, 64'h1F);
      applyStimulus(1'b1, 32'hDEADBEEF, 7'h05, 64'h1234, 1'b1, 1'b0);
      check("badop_err", 64'(err64), 64'd1);
      check("badop_imm", imm64, 64'd0);
      check("badop_tgt", tgt64, 64'd0);
      applyStimulus(1'b1, 32'h000F8000, 7'h40, 64'h0, 1'b1, 1'b0);
      check("csr_imm", imm64, 64'h1F);
      applyStimulus(1'b0, 32'h0, 7'h0, 64'h0, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'h00100093, 7'h10, 64'h10, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00200093, 7'h10, 64'h20, 1'b0, 1'b0);
      check("bp_ready_drop", 64'(rdy32), 64'd0);
      applyStimulus(1'b1, 32'h00300093, 7'h10, 64'h30, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 7'h0, 64'h0, 1'b1, 1'b0);
      check("bp_ready_back", 64'(rdy32), 64'd1);
      check("bp_second", {32'd0, imm32}, 64'h2);
      applyStimulus(1'b0, 32'h0, 7'h0, 64'h0, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'h12345013, 7'h08, 64'h40, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h9ABCD013, 7'h01, 64'h44, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h55555013, 7'h10, 64'h48, 1'b0, 1'b1);
      check("flush_valid", 64'(vld32), 64'd0);
      check("flush_ready", 64'(rdy64), 64'd1);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom, ops[$urandom_range(0, 7)],
                       {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 29) == 0);
      end

      applyStimulus(1'b1, 32'hFFF00093, 7'h10, 64'h100, 1'b0, 1'b0);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("arst_valid", 64'(vld64), 64'd0);
      check("arst_ready", 64'(rdy64), 64'd1);
      check("arst_imm", imm64, 64'd0);
      check("arst_tgt", tgt64, 64'd0);
      check("arst_err", 64'(err32), 64'd0);
      q.delete();
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(1'b1, 32'h00000037, 7'h02, 64'h8, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 7'h0, 64'h0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate generator for the decode stage of the pipelined RISC-V core. It extracts and sign- or zero-extends the I/S/B/U/J/shamt/CSR immediate for a configurable XLEN and computes `pc + imm` for PC-relative ops. Results pass through a 2-entry skid buffer with valid/ready handshakes on both sides, so the block sits between IF/ID and ID/EX and absorbs back-pressure without combinational ready paths.

## Interface
- `XLEN`, default 32: datapath width; only 32 and 64 are legal, enforced by an elaboration-time check.
- `EXTOP_W`, default 7: width of the one-hot extension-op field.
- `clk` input 1: clock, rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `flush` input 1: synchronous pipeline kill.
- `in_valid` input 1: upstream entry valid.
- `in_ready` output 1: block can accept; driven directly from a register.
- `in_instr` input 32: raw instruction.
- `in_pc` input XLEN: PC of the instruction.
- `in_extop` input EXTOP_W: one-hot extension op.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: downstream accepts.
- `out_imm` output XLEN: extended immediate.
- `out_target` output XLEN: `pc + imm`, modulo 2^XLEN.
- `out_err` output 1: `in_extop` was not one-hot; `out_imm` and `out_target` are then 0.

## Operation
- One-hot extension-op codes (unlisted bits are 0):
  - `SHAMT` = bit 5.
  - `ITYPE` = bit 4.
  - `STYPE` = bit 3.
  - `BTYPE` = bit 2.
  - `UTYPE` = bit 1.
  - `JTYPE` = bit 0.
  - `CSRTYPE` = bit 6 (new).
- Immediate formation, with sign extension to XLEN unless stated:
  - `SHAMT`: zero-extended `instr[24:20]` when XLEN=32, `instr[25:20]` when XLEN=64.
  - `ITYPE`: `instr[31:20]`.
  - `STYPE`: `{instr[31:25], instr[11:7]}`.
  - `BTYPE`: `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`. This is byte-scaled, unlike the old unscaled form.
  - `JTYPE`: `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`. Also byte-scaled.
  - `UTYPE`: `{instr[31:12], 12'b0}`, sign-extended from bit 31 when XLEN=64.
  - `CSRTYPE`: zero-extended `instr[19:15]` (uimm).
- `extop` that is zero or has more than one bit set: `imm` = 0, `target` = 0, `err` = 1.
- `target` = `in_pc + imm` for every op. The consumer ignores it for non-PC-relative ops.
- Skid buffer is a 2-entry FIFO, states `EMPTY`, `ONE`, `TWO`:
  - Accept occurs when `in_valid & in_ready`; pop occurs when `out_valid & out_ready`.
  - `EMPTY` → `ONE` on accept.
  - `ONE` → `TWO` on accept without pop.
  - `ONE` → `EMPTY` on pop without accept.
  - `ONE` stays `ONE` on simultaneous accept and pop.
  - `TWO` → `ONE` on pop. No accept is possible in `TWO`.
- `in_ready` = (state ≠ `TWO`), registered.
- `out_valid` = (state ≠ `EMPTY`).
- Outputs always show the oldest entry; order is strictly FIFO.
- `flush` forces `EMPTY` next cycle. An `in_valid` presented in the flush cycle is dropped, and any pop in that cycle is still counted by downstream.
- Output payload is held stable while `out_valid & !out_ready`.

## Timing
- Latency: accept at edge N makes the entry visible on `out_*` after edge N; it can be popped at edge N+1.
- Throughput: 1 per cycle while `out_ready` is held high.
- Reset (async assert, sync-safe release): state = `EMPTY`, `in_ready` = 1, `out_valid` = 0, `out_imm` = 0, `out_target` = 0, `out_err` = 0. Both buffer entries are cleared to 0.
- Reset mid-transfer: all entries are lost and nothing is replayed.
- `flush` together with `rstn` low: reset wins.

## Structure
- Shared package `ext_pkg` holds:
  - The EXTOP bit-index constants above, replacing the old 6-bit defines. Existing codes stay bit-compatible when zero-extended.
  - The `ext_state_t` enum (`EMPTY`, `ONE`, `TWO`).
  - A payload struct (`imm`, `target`, `err`).
- Sub-module `imm_ext_comb` does the pure combinational formation of imm/target/err, parametrised by XLEN.
- `imm_ext_pipe` wraps it with the skid-buffer control and storage.

## Test plan
- XLEN=32, `ITYPE`, instr=0xFFF00093 (`addi x1,x0,-1`), pc=0x100 → imm 0xFFFFFFFF, target 0x000000FF, err 0, one cycle after accept.
- XLEN=32, `BTYPE`, instr=0xFE000EE3 (`beq` −4), pc=0x200 → imm 0xFFFFFFFC, target 0x1FC.
- XLEN=64, `UTYPE`, instr=0x800000B7 → imm 0xFFFFFFFF80000000. Same config with `SHAMT` and instr[25:20]=0x3F → imm 0x3F.
- Back-pressure: 3 back-to-back accepts with `out_ready` = 0 → `in_ready` drops after the 2nd and the 3rd is not accepted. Then raise `out_ready` → entries 1 and 2 pop in order and `in_ready` returns to 1 the same cycle as the first pop.
- `extop` = 0x05 (two bits set) → err 1, imm 0, target 0. `extop` = 0x40 with instr[19:15]=0x1F → imm 0x1F.
- Buffer in `TWO`, assert `flush` for one cycle → `out_valid` 0 and `in_ready` 1 next cycle. Assert `rstn` low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
